alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single execute-stage `alu` between two requesters: requester 0 (execute datapath) and requester 1 (address/branch helper). Two-stage pipeline: an issue register holds the arbitrated operands, and the ALU evaluates them combinationally. Results and condition flags land in a one-entry response buffer with per-requester valid/ready handshake. Owns the architectural NZCV flag register when flags are compiled in.

## Interface
- `WORD`, from constants.vh (64): operand/result width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; one clock, reset synchronous active-high.
- `req0_valid`, `req1_valid`  in  1 each  request present.
- `req0_ready`, `req1_ready`  out  1 each  request accepted this cycle when valid&ready.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WORD each  operands.
- `req0_ctrl`, `req1_ctrl`  in  4 each  ALU op (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUBTRACT`, `ALU_PASS_B`, `ALU_NOR`, `ALU_XOR`).
- `req0_set_flags`, `req1_set_flags`  in  1 each  op updates NZCV.
- `alu_a`, `alu_b`  out  WORD  to ALU, driven from issue register.
- `alu_control`  out  4  to ALU.
- `alu_result`  in  WORD; `alu_zero`, `alu_negative`, `alu_carry`, `alu_overflow`  in  1 each  from ALU.
- `rsp0_valid`, `rsp1_valid`  out  1 each  response for that requester.
- `rsp0_ready`, `rsp1_ready`  in  1 each  consumer accepts.
- `rsp_result`  out  WORD  buffered result (shared; qualified by rspN_valid).
- `rsp_nzcv`  out  4  flags produced by the buffered op, {N,Z,C,V}.
- `flags`  out  4  architectural NZCV register.

## Operation
- Issue register: {iv, id, a, b, ctrl, sf}. Response buffer: {ov, id, result, nzcv}.
- Buffer advance `adv = ~ov | (ov & rsp<id>_ready)`. Issue accept `acc = ~iv | adv`.
- Arbitration: round-robin on `last` bit. One valid -> it wins. Both valid -> requester != `last` wins. `last` updates only on handshake.
- `reqN_ready = acc & grant==N`; combinational from valids, `last`, ov, iv, rspN_ready. Loser's ready = 0.
- On handshake: issue register loads the winner, iv=1. On `acc` without handshake: iv=0.
- On `adv & iv`: buffer loads {id, alu_result, nzcv}, ov=1. On `adv & ~iv`: ov=0.
- nzcv = {alu_negative, alu_zero, alu_carry==1, alu_overflow==1}. Z/X on carry or overflow are captured as 0.
- When iv=0, `alu_a`/`alu_b`/`alu_control` hold their last values; no toggle requirement.
- Unknown ctrl codes are passed through. Whatever the ALU returns is buffered.

## Timing
- Reset values: iv=0, ov=0, `last`=1 (requester 0 wins first tie), `flags`=0, `rsp_result`=0, `rsp_nzcv`=0, both rspN_valid=0. Both reqN_ready evaluate from ov=0, iv=0.
- Latency: handshake at edge E -> buffer loaded at E+1 -> rspN_valid high in the cycle after E+1. Two cycles.
- Throughput: one op/cycle while the consumer holds ready. Round-robin alternates under continuous contention.
- Backpressure: rspN_valid held with result stable until rspN_ready. If iv=1 too, both stages freeze and both reqN_ready=0.
- Simultaneous consume and new result: buffer replaced the same edge with no bubble.
- Reset mid-operation drops in-flight and buffered ops with no response. `flags` clears.

## Configuration
- `ALU_ARB_FLAGS_EN` defined: `flags` loads nzcv on the same edge the buffer loads an op with sf=1. sf=0 ops leave it unchanged. `rsp_nzcv` is valid.
- Not defined: no flag register. `flags` and `rsp_nzcv` are tied to 0, and reqN_set_flags are ignored.

## Test plan
- Reset then single req0 ADD a=5, b=7 -> req0_ready=1 same cycle; rsp0_valid two cycles later, rsp_result=12, rsp_nzcv=0000; rsp1_valid stays 0.
- Both requesters valid for 4 cycles with rsp ready=1 -> grants 0,1,0,1; responses arrive in that order, one per cycle.
- req1 SUBTRACT a=3, b=5, sf=1 with FLAGS_EN -> rsp_result=-2, flags=1000. A following sf=0 AND leaves flags=1000.
- req0 ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1, sf=1 -> rsp_nzcv=1001 (N, V); carry input Z is captured as 0.
- rsp0_ready=0 for 3 cycles with two ops queued -> rsp0_valid and rsp_result stable; req0_ready=0 while both stages are full; drains in order once ready rises.
- Assert reset while iv=1 and ov=1 -> next cycle rsp valids=0 and flags=0000; a tie that follows is won by req0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels, the shared ALU hookup and the response
// channels used by alu_arbiter.
interface alu_arbiter_if #(
    parameter int WORD = 64
);
    logic            req0_valid;
    logic            req1_valid;
    logic            req0_ready;
    logic            req1_ready;
    logic [WORD-1:0] req0_a;
    logic [WORD-1:0] req0_b;
    logic [WORD-1:0] req1_a;
    logic [WORD-1:0] req1_b;
    logic [3:0]      req0_ctrl;
    logic [3:0]      req1_ctrl;
    logic            req0_set_flags;
    logic            req1_set_flags;

    logic [WORD-1:0] alu_a;
    logic [WORD-1:0] alu_b;
    logic [3:0]      alu_control;
    logic [WORD-1:0] alu_result;
    logic            alu_zero;
    logic            alu_negative;
    logic            alu_carry;
    logic            alu_overflow;

    logic            rsp0_valid;
    logic            rsp1_valid;
    logic            rsp0_ready;
    logic            rsp1_ready;
    logic [WORD-1:0] rsp_result;
    logic [3:0]      rsp_nzcv;
    logic [3:0]      flags;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_ctrl, req1_ctrl, req0_set_flags, req1_set_flags,
               alu_result, alu_zero, alu_negative, alu_carry, alu_overflow,
               rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_control,
               rsp0_valid, rsp1_valid, rsp_result, rsp_nzcv, flags
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_ctrl, req1_ctrl, req0_set_flags, req1_set_flags,
               alu_result, alu_zero, alu_negative, alu_carry, alu_overflow,
               rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_control,
               rsp0_valid, rsp1_valid, rsp_result, rsp_nzcv, flags
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters: issue register -> ALU -> one-entry
// response buffer. Define ALU_ARB_FLAGS_EN to build the NZCV flag register and rsp_nzcv.
module alu_arbiter #(
    parameter int WORD = 64
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);
    logic            iv_reg;
    logic            id_reg;
    logic            sf_reg;
    logic [WORD-1:0] a_reg;
    logic [WORD-1:0] b_reg;
    logic [3:0]      ctrl_reg;

    logic            ov_reg;
    logic            oid_reg;
    logic [WORD-1:0] result_reg;
    logic            last_reg;

    logic            any_valid;
    logic            grant;
    logic            adv;
    logic            acc;
    logic            hs;
    logic [3:0]      nzcv_in;

    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        // Requester 1 wins when alone, or on a tie when requester 0 went last.
        grant     = bus.req1_valid & (~bus.req0_valid | ~last_reg);
        adv       = ~ov_reg | (oid_reg ? bus.rsp1_ready : bus.rsp0_ready);
        acc       = ~iv_reg | adv;
        hs        = acc & any_valid;
        // Anything other than a clean 1 on carry/overflow is recorded as 0.
        nzcv_in   = {bus.alu_negative, bus.alu_zero,
                     bus.alu_carry === 1'b1, bus.alu_overflow === 1'b1};
    end

    assign bus.req0_ready  = acc & ~grant;
    assign bus.req1_ready  = acc & grant;
    assign bus.alu_a       = a_reg;
    assign bus.alu_b       = b_reg;
    assign bus.alu_control = ctrl_reg;
    assign bus.rsp0_valid  = ov_reg & ~oid_reg;
    assign bus.rsp1_valid  = ov_reg & oid_reg;
    assign bus.rsp_result  = result_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            iv_reg   <= 1'b0;
            id_reg   <= 1'b0;
            sf_reg   <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            ctrl_reg <= '0;
            last_reg <= 1'b1;
        end else if (acc) begin
            iv_reg <= hs;
            if (hs) begin
                id_reg   <= grant;
                last_reg <= grant;
                a_reg    <= grant ? bus.req1_a : bus.req0_a;
                b_reg    <= grant ? bus.req1_b : bus.req0_b;
                ctrl_reg <= grant ? bus.req1_ctrl : bus.req0_ctrl;
                sf_reg   <= grant ? bus.req1_set_flags : bus.req0_set_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ov_reg     <= 1'b0;
            oid_reg    <= 1'b0;
            result_reg <= '0;
        end else if (adv) begin
            ov_reg <= iv_reg;
            if (iv_reg) begin
                oid_reg    <= id_reg;
                result_reg <= bus.alu_result;
            end
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    logic [3:0] nzcv_reg;
    logic [3:0] flags_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            nzcv_reg  <= '0;
            flags_reg <= '0;
        end else if (adv & iv_reg) begin
            nzcv_reg <= nzcv_in;
            if (sf_reg) begin
                flags_reg <= nzcv_in;
            end
        end
    end

    assign bus.rsp_nzcv = nzcv_reg;
    assign bus.flags    = flags_reg;
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = &{1'b0, sf_reg, nzcv_in};

    assign bus.rsp_nzcv = '0;
    assign bus.flags    = '0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU closes the loop, expected
// responses are queued at request handshake and checked as responses are consumed.
module tb_alu_arbiter;
    localparam int WORD = 64;
    localparam logic [3:0] ALU_AND      = 4'b0000;
    localparam logic [3:0] ALU_OR       = 4'b0001;
    localparam logic [3:0] ALU_ADD      = 4'b0010;
    localparam logic [3:0] ALU_XOR      = 4'b0011;
    localparam logic [3:0] ALU_SUBTRACT = 4'b0110;
    localparam logic [3:0] ALU_PASS_B   = 4'b0111;
    localparam logic [3:0] ALU_NOR      = 4'b1100;
    localparam logic [3:0] OP_TAB [7] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_XOR,
                                          ALU_SUBTRACT, ALU_PASS_B, ALU_NOR};
`ifdef ALU_ARB_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    typedef struct packed {
        logic        id;
        logic [63:0] result;
        logic [3:0]  nzcv;
        logic        sf;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    alu_arbiter_if #(.WORD(WORD)) ifc ();

    alu_arbiter #(.WORD(WORD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    exp_t       sb_q[$];
    logic       grant_q[$];
    int         n_compared = 0;
    int         n_mismatched = 0;
    logic [3:0] model_flags = 4'b0000;

    // Returns {N, Z, C, V, result}; C on subtract means "no borrow".
    function automatic logic [67:0] alu_model(input logic [3:0] ctrl,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [64:0] wide;
        logic [63:0] r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        case (ctrl)
            ALU_AND:      r = a & b;
            ALU_OR:       r = a | b;
            ALU_XOR:      r = a ^ b;
            ALU_NOR:      r = ~(a | b);
            ALU_PASS_B:   r = b;
            ALU_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[63:0];
                c = wide[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            ALU_SUBTRACT: begin
                r = a - b;
                c = (a >= b);
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            default:      r = a;
        endcase
        return {r[63], r == 64'd0, c, v, r};
    endfunction

    logic [67:0] alu_out;
    assign alu_out          = alu_model(ifc.alu_control, ifc.alu_a, ifc.alu_b);
    assign ifc.alu_result   = alu_out[63:0];
    assign ifc.alu_negative = alu_out[67];
    assign ifc.alu_zero     = alu_out[66];
    assign ifc.alu_carry    = alu_out[65];
    assign ifc.alu_overflow = alu_out[64];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: consume before push so older entries leave first.
    exp_t        mon_e;
    logic [67:0] mon_m;
    always @(negedge clk) begin
        if (!reset) begin
            if ((ifc.rsp0_valid && ifc.rsp0_ready) || (ifc.rsp1_valid && ifc.rsp1_ready)) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rsp_both_valid", 64'(ifc.rsp0_valid & ifc.rsp1_valid), 64'd0);
                    check("rsp_id", 64'(ifc.rsp1_valid), 64'(mon_e.id));
                    check("rsp_result", ifc.rsp_result, mon_e.result);
                    check("rsp_nzcv", 64'(ifc.rsp_nzcv), FLAGS_EN ? 64'(mon_e.nzcv) : 64'd0);
                    if (FLAGS_EN && mon_e.sf) model_flags = mon_e.nzcv;
                    check("flags", 64'(ifc.flags), 64'(model_flags));
                    $display("rsp id=%0d result=%h nzcv=%b flags=%b",
                             mon_e.id, ifc.rsp_result, ifc.rsp_nzcv, ifc.flags);
                end
            end
            check("ready_exclusive", 64'(ifc.req0_ready & ifc.req1_ready), 64'd0);
            if (ifc.req0_valid && ifc.req0_ready) begin
                mon_m = alu_model(ifc.req0_ctrl, ifc.req0_a, ifc.req0_b);
                sb_q.push_back('{1'b0, mon_m[63:0], mon_m[67:64], ifc.req0_set_flags});
                grant_q.push_back(1'b0);
            end
            if (ifc.req1_valid && ifc.req1_ready) begin
                mon_m = alu_model(ifc.req1_ctrl, ifc.req1_a, ifc.req1_b);
                sb_q.push_back('{1'b1, mon_m[63:0], mon_m[67:64], ifc.req1_set_flags});
                grant_q.push_back(1'b1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        grant_q.delete();
        model_flags = 4'b0000;
    endtask

    task automatic set_req(input logic id, input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] ctrl, input logic sf);
        if (id) begin
            ifc.req1_a = a; ifc.req1_b = b; ifc.req1_ctrl = ctrl;
            ifc.req1_set_flags = sf; ifc.req1_valid = 1'b1;
        end else begin
            ifc.req0_a = a; ifc.req0_b = b; ifc.req0_ctrl = ctrl;
            ifc.req0_set_flags = sf; ifc.req0_valid = 1'b1;
        end
    endtask

    task automatic wait_hs(input logic id);
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = id ? ifc.req1_ready : ifc.req0_ready;
        end
        if (!got) check("hs_timeout", 64'd0, 64'd1);
        tick();
        if (id) ifc.req1_valid = 1'b0;
        else    ifc.req0_valid = 1'b0;
    endtask

    task automatic issue(input logic id, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] ctrl, input logic sf);
        set_req(id, a, b, ctrl, sf);
        wait_hs(id);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain", 64'(sb_q.size()), 64'd0);
        tick();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    localparam logic GRANT_EXP [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        logic        w;
        logic [63:0] held;
        ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
        ifc.req0_a = '0; ifc.req0_b = '0; ifc.req0_ctrl = '0; ifc.req0_set_flags = 1'b0;
        ifc.req1_a = '0; ifc.req1_b = '0; ifc.req1_ctrl = '0; ifc.req1_set_flags = 1'b0;
        ifc.rsp0_ready = 1'b1; ifc.rsp1_ready = 1'b1;
        tick();
        do_reset();

        // Reset state and single ADD with two-cycle latency.
        @(negedge clk);
        check("rst_rsp0_valid", 64'(ifc.rsp0_valid), 64'd0);
        check("rst_rsp1_valid", 64'(ifc.rsp1_valid), 64'd0);
        check("rst_flags", 64'(ifc.flags), 64'd0);
        check("rst_rsp_result", ifc.rsp_result, 64'd0);
        check("rst_rsp_nzcv", 64'(ifc.rsp_nzcv), 64'd0);
        tick();
        set_req(1'b0, 64'd5, 64'd7, ALU_ADD, 1'b0);
        @(negedge clk);
        check("t1_req0_ready", 64'(ifc.req0_ready), 64'd1);
        check("t1_req1_ready", 64'(ifc.req1_ready), 64'd0);
        tick();
        ifc.req0_valid = 1'b0;
        @(negedge clk);
        check("t1_rsp0_early", 64'(ifc.rsp0_valid), 64'd0);
        @(negedge clk);
        check("t1_rsp0_valid", 64'(ifc.rsp0_valid), 64'd1);
        check("t1_rsp_result", ifc.rsp_result, 64'd12);
        check("t1_rsp1_valid", 64'(ifc.rsp1_valid), 64'd0);
        drain();

        // Continuous contention alternates 0,1,0,1.
        do_reset();
        set_req(1'b0, rnd64(), rnd64(), OP_TAB[$urandom_range(0, 6)], 1'($urandom));
        set_req(1'b1, rnd64(), rnd64(), OP_TAB[$urandom_range(0, 6)], 1'($urandom));
        for (int k = 0; k < 4; k++) begin
            tick();
            if (grant_q.size() != 0) begin
                w = grant_q[grant_q.size() - 1];
                set_req(w, rnd64(), rnd64(), OP_TAB[$urandom_range(0, 6)], 1'($urandom));
            end
        end
        ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
        check("t2_grant_count", 64'(grant_q.size()), 64'd4);
        for (int k = 0; k < 4 && k < grant_q.size(); k++)
            check("t2_grant_order", 64'(grant_q[k]), 64'(GRANT_EXP[k]));
        drain();

        // Flag-setting SUBTRACT, then AND without set_flags.
        issue(1'b1, 64'd3, 64'd5, ALU_SUBTRACT, 1'b1);
        issue(1'b1, 64'hF0F0, 64'h0FF0, ALU_AND, 1'b0);
        drain();
        check("t3_flags", 64'(ifc.flags), FLAGS_EN ? 64'h8 : 64'd0);

        // Signed overflow on ADD.
        issue(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 1'b1);
        drain();
        check("t4_flags", 64'(ifc.flags), FLAGS_EN ? 64'h9 : 64'd0);

        // Backpressure: both stages fill, req0 stalls, result holds.
        ifc.rsp0_ready = 1'b0;
        issue(1'b0, 64'd100, 64'd23, ALU_SUBTRACT, 1'b0);
        issue(1'b0, 64'hAA, 64'h55, ALU_OR, 1'b0);
        set_req(1'b0, 64'd1, 64'd2, ALU_PASS_B, 1'b0);
        held = 64'd77;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_req0_ready", 64'(ifc.req0_ready), 64'd0);
            check("t5_rsp0_valid", 64'(ifc.rsp0_valid), 64'd1);
            check("t5_rsp_result", ifc.rsp_result, held);
        end
        tick();
        ifc.rsp0_ready = 1'b1;
        wait_hs(1'b0);
        drain();

        // Reset with both stages occupied, then a tie.
        ifc.rsp0_ready = 1'b0;
        issue(1'b0, 64'd3, 64'd5, ALU_SUBTRACT, 1'b1);
        issue(1'b0, 64'd1, 64'd1, ALU_ADD, 1'b0);
        @(negedge clk);
        check("t6_pre_flags", 64'(ifc.flags), FLAGS_EN ? 64'h8 : 64'd0);
        do_reset();
        ifc.rsp0_ready = 1'b1;
        @(negedge clk);
        check("t6_rsp0_valid", 64'(ifc.rsp0_valid), 64'd0);
        check("t6_rsp1_valid", 64'(ifc.rsp1_valid), 64'd0);
        check("t6_flags", 64'(ifc.flags), 64'd0);
        tick();
        set_req(1'b0, 64'd9, 64'd4, ALU_XOR, 1'b0);
        set_req(1'b1, 64'd8, 64'd2, ALU_NOR, 1'b0);
        @(negedge clk);
        check("t6_tie_req0", 64'(ifc.req0_ready), 64'd1);
        check("t6_tie_req1", 64'(ifc.req1_ready), 64'd0);
        tick();
        ifc.req0_valid = 1'b0;
        wait_hs(1'b1);
        drain();

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
